// File: rtl/seq_multiplier_ctrl.sv
// Sequential WIDTH x WIDTH unsigned multiplier.
// The operands are split into 2-bit digits, and one shared 2x2 multiplier
// produces one partial product per cycle.

// 2x2 unsigned multiplier, purely combinational.
module two_bit_multiplier (
  input  logic [1:0] x,
  input  logic [1:0] y,
  output logic [3:0] p
);

  // Full 4-bit product of two 2-bit digits.
  always_comb begin
    p = 4'(x) * 4'(y);
  end

endmodule

// Valid/ready wrapped digit-serial multiply sequencer.
module seq_multiplier_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int unsigned D  = WIDTH / 2;
  localparam int unsigned IW = (D > 1) ? $clog2(D) : 1;
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned SW = $clog2(PW) + 1;
  localparam logic [IW-1:0] LAST = IW'(D - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [IW-1:0]    i_q, i_d;
  logic [IW-1:0]    j_q, j_d;

  logic [1:0]       a_dig;
  logic [1:0]       b_dig;
  logic [3:0]       pp4;
  logic [SW-1:0]    shamt;
  logic [PW-1:0]    pp_shifted;

  // Select the current digit pair and the shift that aligns its partial product.
  always_comb begin
    a_dig      = 2'(a_q >> {i_q, 1'b0});
    b_dig      = 2'(b_q >> {j_q, 1'b0});
    shamt      = SW'({i_q, 1'b0}) + SW'({j_q, 1'b0});
    pp_shifted = PW'(pp4) << shamt;
  end

  two_bit_multiplier u_mul (
    .x (a_dig),
    .y (b_dig),
    .p (pp4)
  );

  // Next-state logic and datapath updates.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    i_d     = i_q;
    j_d     = j_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = acc_q + pp_shifted;
        if (j_q == LAST) begin
          j_d = '0;
          if (i_q == LAST) begin
            i_d     = '0;
            state_d = DONE;
          end else begin
            i_d = i_q + IW'(1);
          end
        end else begin
          j_d = j_q + IW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath registers and registered handshake/status decodes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      i_q       <= '0;
      j_q       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      i_q       <= i_d;
      j_q       <= j_d;
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
      busy      <= (state_d != IDLE);
    end
  end

  assign product = acc_q;

endmodule

// File: tb/tb_seq_multiplier_ctrl.sv
// Directed and randomised checks for seq_multiplier_ctrl at WIDTH=8 and WIDTH=2.
module tb_seq_multiplier_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] product;
  logic        busy;

  logic        in_valid2 = 1'b0;
  logic        in_ready2;
  logic [1:0]  a2 = '0;
  logic [1:0]  b2 = '0;
  logic        out_valid2;
  logic        out_ready2 = 1'b0;
  logic [3:0]  product2;
  logic        busy2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  seq_multiplier_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  seq_multiplier_ctrl #(.WIDTH(2)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .a         (a2),
    .b         (b2),
    .out_valid (out_valid2),
    .out_ready (out_ready2),
    .product   (product2),
    .busy      (busy2)
  );

  // Count one comparison and report it when it does not hold.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One WIDTH=8 transaction: accept, count latency, optional backpressure, drain.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input int hold,
                        input bit pre_ready, input bit pulse);
    logic [15:0] exp;
    int          cnt;
    bit          calc_ok;
    bit          hold_ok;
    exp = 16'(av) * 16'(bv);
    @(negedge clk);
    check("accept_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a = av;
    b = bv;
    out_ready = pre_ready;
    @(negedge clk);
    in_valid = 1'b0;
    cnt = 0;
    calc_ok = 1'b1;
    while (!out_valid && cnt < 200) begin
      if (in_ready !== 1'b0 || busy !== 1'b1) calc_ok = 1'b0;
      if (pulse && cnt == 3) begin
        in_valid = 1'b1;
        a = 8'h77;
        b = 8'h77;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      cnt++;
    end
    in_valid = 1'b0;
    check("latency", 32'(cnt), 32'd16);
    check("calc_in_ready_low_busy_high", 32'(calc_ok), 32'd1);
    check("product", 32'(product), 32'(exp));
    check("done_in_ready_low", 32'(in_ready), 32'd0);
    if (!pre_ready) begin
      hold_ok = 1'b1;
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        if (out_valid !== 1'b1 || product !== exp || in_ready !== 1'b0) hold_ok = 1'b0;
      end
      check("backpressure_hold", 32'(hold_ok), 32'd1);
      out_ready = 1'b1;
    end
    @(negedge clk);
    out_ready = 1'b0;
    check("drain_out_valid", 32'(out_valid), 32'd0);
    check("drain_in_ready", 32'(in_ready), 32'd1);
    check("idle_product_hold", 32'(product), 32'(exp));
  endtask

  initial begin
    int cnt;
    bit quiet;
    logic [7:0] ra;
    logic [7:0] rb;

    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_product", 32'(product), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Directed cases.
    run_op(8'hFF, 8'hFF, 0, 1'b1, 1'b0);
    run_op(8'h00, 8'hA5, 0, 1'b1, 1'b0);
    run_op(8'h01, 8'hA5, 0, 1'b1, 1'b0);
    run_op(8'h12, 8'h34, 5, 1'b0, 1'b0);
    run_op(8'h03, 8'h05, 2, 1'b0, 1'b1);

    // No second result may appear after the ignored in_valid pulse.
    quiet = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) quiet = 1'b0;
    end
    check("no_queued_op", 32'(quiet), 32'd1);
    check("pulse_product_kept", 32'(product), 32'h000F);

    // Reset in the middle of CALC.
    @(negedge clk);
    in_valid = 1'b1;
    a = 8'hFF;
    b = 8'hFF;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("mid_calc_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_product", 32'(product), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h10, 8'h10, 1, 1'b0, 1'b0);

    // Exhaustive WIDTH=2.
    out_ready2 = 1'b1;
    for (int x = 0; x < 4; x++) begin
      for (int y = 0; y < 4; y++) begin
        @(negedge clk);
        in_valid2 = 1'b1;
        a2 = 2'(x);
        b2 = 2'(y);
        @(negedge clk);
        in_valid2 = 1'b0;
        cnt = 0;
        while (!out_valid2 && cnt < 50) begin
          @(negedge clk);
          cnt++;
        end
        check("w2_latency", 32'(cnt), 32'd1);
        check("w2_product", 32'(product2), 32'(x * y));
        @(negedge clk);
        check("w2_drain", 32'(out_valid2), 32'd0);
      end
    end
    out_ready2 = 1'b0;

    // Random WIDTH=8 pairs with random output backpressure.
    for (int n = 0; n < 300; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      run_op(ra, rb, int'($urandom_range(0, 3)), 1'($urandom), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
